jt89_mixer: RTL and testbench



---
 rtl/jt89_mixer.sv | 135 +++++++++++++
 tb/tb_jt89_mixer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/jt89_mixer.sv
// jt89_mixer: mutes and sums the three tone channels plus noise with a
// time-multiplexed accumulator, then an optional first-order DC-blocking
// high-pass filter. One signed 12-bit sample is produced per sample strobe.
//
// Timing: sample_en sampled at edge E -> busy from E to E+5 and ACC for
// four cycles, then DC for one cycle. The DC cycle is the output cycle:
// it computes the result and registers snd/snd_valid. snd_valid therefore
// shows up six cycles after the strobe, with the FSM already back in IDLE,
// so a new strobe can be taken in that same cycle.
module jt89_mixer #(
  parameter int DCEN = 1,
  parameter int DCW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic signed [9:0] ch0,
  input  logic signed [9:0] ch1,
  input  logic signed [9:0] ch2,
  input  logic signed [9:0] noise,
  input  logic        [3:0] mute,
  output logic signed [11:0] snd,
  output logic              snd_valid,
  output logic              busy
);

  // Filter state is y scaled by 2^DCW; sums are done two bits wider so the
  // clamp sees the true value before narrowing.
  localparam int YW = 14 + DCW;
  localparam int SW = YW + 2;
  localparam logic signed [SW-1:0] YLIM = (SW'(1) <<< (13 + DCW)) - SW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DC   = 2'd2;

  logic        [1:0]    state_q;
  logic        [1:0]    idx_q;
  logic signed [9:0]    chan_q [4];
  logic        [3:0]    mute_q;
  logic signed [11:0]   acc_q;
  logic signed [11:0]   xprev_q;
  logic signed [YW-1:0] y_q;
  logic signed [11:0]   snd_q;
  logic                 vld_q;
  logic                 busy_q;

  logic signed [11:0]   acc_d;
  logic signed [12:0]   d_diff;
  logic signed [SW-1:0] y_sum;
  logic signed [YW-1:0] y_d;
  logic signed [11:0]   filt;
  logic signed [11:0]   result;

  // Clamp the wide filter sum to +/-(2^(13+DCW)-1).
  function automatic logic signed [YW-1:0] clamp_y(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] r;
    if (v > YLIM)       r = YLIM;
    else if (v < -YLIM) r = -YLIM;
    else                r = v;
    return r[YW-1:0];
  endfunction

  // Saturate the descaled filter output to the 12-bit sample range.
  function automatic logic signed [11:0] sat12(input logic signed [13:0] v);
    logic signed [13:0] r;
    if (v > 14'sd2047)       r = 14'sd2047;
    else if (v < -14'sd2048) r = -14'sd2048;
    else                     r = v;
    return r[11:0];
  endfunction

  // Accumulator step and DC-blocking filter datapath.
  always_comb begin
    acc_d  = acc_q + 12'(chan_q[idx_q]);
    d_diff = 13'(acc_q) - 13'(xprev_q);
    y_sum  = SW'(y_q) - SW'(y_q >>> DCW) + (SW'(d_diff) <<< DCW);
    y_d    = clamp_y(y_sum);
    // Dropping the low DCW bits is an arithmetic shift with floor rounding.
    filt   = sat12(y_d[YW-1:DCW]);
    result = (DCEN != 0) ? filt : acc_q;
  end

  // Mix sequencer: snapshot, accumulate four channels, filter and emit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      for (int i = 0; i < 4; i++) chan_q[i] <= '0;
      mute_q  <= '0;
      acc_q   <= '0;
      xprev_q <= '0;
      y_q     <= '0;
      snd_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sample_en) begin
            chan_q[0] <= ch0;
            chan_q[1] <= ch1;
            chan_q[2] <= ch2;
            chan_q[3] <= noise;
            mute_q    <= mute;
            acc_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_ACC;
          end
        end
        S_ACC: begin
          if (!mute_q[idx_q]) acc_q <= acc_d;
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= S_DC;
        end
        S_DC: begin
          y_q     <= y_d;
          xprev_q <= acc_q;
          snd_q   <= result;
          vld_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign snd       = snd_q;
  assign snd_valid = vld_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_jt89_mixer.sv
// Directed bench for jt89_mixer: one instance without the DC filter and one
// with it (DCW=8), driven from the same inputs.
module tb_jt89_mixer;

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_en;
  logic signed [9:0] ch0, ch1, ch2, noise;
  logic        [3:0] mute;
  logic signed [11:0] snd0, snd1;
  logic              vld0, vld1, busy0, busy1;

  int nvec = 0;
  int nerr = 0;
  int pulses;

  always #5 clk = ~clk;

  jt89_mixer #(.DCEN(0), .DCW(8)) dut0 (
    .clk(clk), .rst(rst), .sample_en(sample_en),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .noise(noise), .mute(mute),
    .snd(snd0), .snd_valid(vld0), .busy(busy0)
  );

  jt89_mixer #(.DCEN(1), .DCW(8)) dut1 (
    .clk(clk), .rst(rst), .sample_en(sample_en),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .noise(noise), .mute(mute),
    .snd(snd1), .snd_valid(vld1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive the strobe in the current cycle; returns one cycle later.
  task automatic start();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  // Full mix: returns in the cycle where snd_valid is expected.
  task automatic mix(input logic signed [9:0] a, input logic signed [9:0] b,
                     input logic signed [9:0] c, input logic signed [9:0] n,
                     input logic [3:0] m);
    ch0 = a; ch1 = b; ch2 = c; noise = n; mute = m;
    start();
    repeat (5) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0;
    ch0 = '0; ch1 = '0; ch2 = '0; noise = '0; mute = '0;
    do_reset();
    chk("rst_snd0", snd0, 0);
    chk("rst_vld0", vld0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_snd1", snd1, 0);
    chk("rst_vld1", vld1, 0);

    // Latency: busy N+1..N+5, valid only at N+6.
    ch0 = 100; ch1 = 0; ch2 = 0; noise = 0; mute = 4'b0000;
    start();
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("lat_busy_n%0d", k), busy0, 1);
      chk($sformatf("lat_vld_n%0d", k), vld0, 0);
      tick();
    end
    chk("lat_vld_n6", vld0, 1);
    chk("lat_snd_n6", snd0, 100);
    chk("lat_busy_n6", busy0, 0);
    tick();
    chk("lat_vld_n7", vld0, 0);
    chk("lat_hold_n7", snd0, 100);

    // Raw sums without filter.
    mix(511, 511, 511, 511, 4'b0000);
    chk("sum_max_vld", vld0, 1);
    chk("sum_max", snd0, 2044);
    mix(-512, -512, -512, -512, 4'b0000);
    chk("sum_min", snd0, -2048);
    mix(0, 300, 0, 0, 4'b0010);
    chk("mute_ch1", snd0, 0);
    mix(100, 20, 3, -7, 4'b0100);
    chk("mute_ch2", snd0, 113);
    mix(100, 100, 100, 100, 4'b1111);
    chk("mute_all", snd0, 0);
    mix(0, 0, 0, -50, 4'b0001);
    chk("noise_only", snd0, -50);

    // DC filter decay: 100, 99, 99, 98 then step down to 0.
    do_reset();
    mix(100, 0, 0, 0, 4'b0000);
    chk("dc_s1_vld", vld1, 1);
    chk("dc_s1", snd1, 100);
    tick();
    mix(100, 0, 0, 0, 4'b0000);
    chk("dc_s2", snd1, 99);
    mix(100, 0, 0, 0, 4'b0000);
    chk("dc_s3", snd1, 99);
    mix(100, 0, 0, 0, 4'b0000);
    chk("dc_s4", snd1, 98);
    mix(0, 0, 0, 0, 4'b0000);
    chk("dc_s5_step", snd1, -2);

    do_reset();
    mix(100, 0, 0, 0, 4'b0000);
    chk("dc_single", snd1, 100);
    mix(0, 0, 0, 0, 4'b0000);
    chk("dc_floor", snd1, -1);

    // Filter saturation on a full-scale positive step.
    do_reset();
    mix(-512, -512, -512, -512, 4'b0000);
    chk("dc_neg_fs", snd1, -2048);
    mix(511, 511, 511, 511, 4'b0000);
    chk("dc_sat_pos", snd1, 2047);
    chk("raw_pos", snd0, 2044);

    // Strobe while busy is ignored; strobe in the valid cycle is taken.
    ch0 = 5; ch1 = 0; ch2 = 0; noise = 0; mute = 4'b0000;
    pulses = 0;
    start();                   // N+1
    ch0 = 77;                  // after snapshot
    if (vld0) pulses++;
    tick();                    // N+2
    if (vld0) pulses++;
    tick();                    // N+3
    if (vld0) pulses++;
    sample_en = 1'b1;
    tick();                    // N+4
    sample_en = 1'b0;
    if (vld0) pulses++;
    tick();                    // N+5
    if (vld0) pulses++;
    chk("ovl_busy_n5", busy0, 1);
    tick();                    // N+6
    chk("ovl_vld_n6", vld0, 1);
    chk("ovl_pulses_before", pulses, 0);
    chk("ovl_snapshot", snd0, 5);
    sample_en = 1'b1;
    tick();                    // N+7
    sample_en = 1'b0;
    chk("ovl_vld_n7", vld0, 0);
    chk("ovl_busy_n7", busy0, 1);
    repeat (4) tick();         // N+11
    chk("ovl_vld_n11", vld0, 0);
    tick();                    // N+12
    chk("ovl_vld_n12", vld0, 1);
    chk("ovl_second", snd0, 77);

    // Reset mid-mix aborts and clears the filter state.
    mix(-512, -512, -512, -512, 4'b0000);
    ch0 = 100; ch1 = 0; ch2 = 0; noise = 0;
    pulses = 0;
    start();                   // N+1
    tick();                    // N+2
    tick();                    // N+3
    rst = 1'b1;
    tick();                    // N+4
    rst = 1'b0;
    chk("abort_vld", vld0, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_snd", snd0, 0);
    chk("abort_busy1", busy1, 0);
    for (int k = 0; k < 4; k++) begin
      if (vld0 || vld1) pulses++;
      tick();
    end
    chk("abort_no_pulse", pulses, 0);
    mix(100, 0, 0, 0, 4'b0000);
    chk("after_abort_vld", vld1, 1);
    chk("after_abort_dc", snd1, 100);
    chk("after_abort_raw", snd0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
